// File: rtl/cpu15_pkg.sv
// cpu15 shared definitions: opcodes, sequencer
// states and the 15-bit instruction field layout.
package cpu15_pkg;

  localparam int INSN_W = 15;

  localparam int OP_HI  = 14;
  localparam int OP_LO  = 11;
  localparam int RA_HI  = 10;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SL  = 4'h5;
  localparam logic [3:0] OP_SR  = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LDL = 4'h8;
  localparam logic [3:0] OP_LDH = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_JE  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LD  = 4'hD;
  localparam logic [3:0] OP_ST  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // IR after reset decodes as HLT so exec stays inert
  localparam logic [INSN_W-1:0] IR_RST =
    {OP_HLT, 11'h000};

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } fd_state_e;

  function automatic logic is_mem_op(
    input logic [3:0] op
  );
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/fd_sequencer.sv
// cpu15 phase sequencer: FETCH/DECODE/EXEC/WB/HALT
// with ROM-latency wait and one-cycle phase strobes.
module fd_sequencer
  import cpu15_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hlt_op,
  output logic o_load_pc,
  output logic o_latch_ir,
  output logic o_ex_en,
  output logic o_wb_en,
  output logic o_halted
);

  localparam logic [1:0] LAT_LAST =
    2'(ROM_LAT - 1);

  fd_state_e  r_state;
  fd_state_e  w_state_nx;
  logic [1:0] r_lat_cnt;
  logic [1:0] w_lat_cnt_nx;

  // phase state and ROM wait counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_lat_cnt <= w_lat_cnt_nx;
    end
  end

  // next phase and the strobes owned by each phase
  always_comb begin
    w_state_nx   = r_state;
    w_lat_cnt_nx = r_lat_cnt;
    o_load_pc    = 1'b0;
    o_latch_ir   = 1'b0;
    o_ex_en      = 1'b0;
    o_wb_en      = 1'b0;
    o_halted     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_lat_cnt_nx = '0;
          w_state_nx   = S_DECODE;
        end else begin
          w_lat_cnt_nx = r_lat_cnt + 2'd1;
        end
      end
      S_DECODE: begin
        o_latch_ir = 1'b1;
        w_state_nx = S_EXEC;
      end
      S_EXEC: begin
        o_ex_en    = 1'b1;
        w_state_nx = S_WB;
      end
      S_WB: begin
        o_wb_en = 1'b1;
        if (i_hlt_op) begin
          w_state_nx = S_HALT;
        end else begin
          o_load_pc  = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        w_state_nx   = S_FETCH;
        w_lat_cnt_nx = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// cpu15 front end: ROM address, instruction
// register, field decode and LD/ST RAM address.
module fetch_decode
  import cpu15_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int PC_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [PC_W-1:0]   P_COUNT,
  output logic [PC_W-1:0]   ROM_ADDR,
  input  logic [INSN_W-1:0] ROM_DATA,
  output logic [3:0]        OP_CODE,
  output logic [2:0]        REG_A_SEL,
  output logic [2:0]        REG_B_SEL,
  output logic [7:0]        OP_DATA,
  output logic [7:0]        RAM_ADDR,
  output logic              EX_EN,
  output logic              WB_EN,
  output logic              HALTED
);

  logic [INSN_W-1:0] r_ir;
  logic [PC_W-1:0]   r_rom_addr;
  logic [7:0]        r_ram_addr;
  logic              w_load_pc;
  logic              w_latch_ir;
  logic              w_hlt_op;
  logic [3:0]        w_rom_op;

  assign w_rom_op = ROM_DATA[OP_HI:OP_LO];
  assign w_hlt_op = r_ir[OP_HI:OP_LO] == OP_HLT;

  fd_sequencer #(
    .ROM_LAT (ROM_LAT)
  ) u_seq (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_hlt_op   (w_hlt_op),
    .o_load_pc  (w_load_pc),
    .o_latch_ir (w_latch_ir),
    .o_ex_en    (EX_EN),
    .o_wb_en    (WB_EN),
    .o_halted   (HALTED)
  );

  // PC sample on entry to FETCH; IR and RAM address in DECODE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rom_addr <= '0;
      r_ir       <= IR_RST;
      r_ram_addr <= '0;
    end else begin
      if (w_load_pc) begin
        r_rom_addr <= P_COUNT;
      end
      if (w_latch_ir) begin
        r_ir <= ROM_DATA;
        if (is_mem_op(w_rom_op)) begin
          r_ram_addr <= ROM_DATA[IMM_HI:IMM_LO];
        end
      end
    end
  end

  assign ROM_ADDR  = r_rom_addr;
  assign OP_CODE   = r_ir[OP_HI:OP_LO];
  assign REG_A_SEL = r_ir[RA_HI:RA_LO];
  assign REG_B_SEL = r_ir[RB_HI:RB_LO];
  assign OP_DATA   = r_ir[IMM_HI:IMM_LO];
  assign RAM_ADDR  = r_ram_addr;

endmodule

// File: tb/tb_fetch_decode.sv
// fetch_decode bench: ROM_LAT=1 and ROM_LAT=3 copies
// checked each cycle against an instruction-level trace.
module tb_fetch_decode;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  always #5 CLK = ~CLK;

  logic [14:0] rom [256];

  logic [7:0] tr_addr [$];
  logic [14:0] tr_insn [$];
  int halt_idx;
  int t;
  int n_total = 0;
  int n_bad = 0;

  // lane with ROM_LAT=1
  logic [7:0]  pc1, ra1, od1, ram1, ad1;
  logic [14:0] rd1;
  logic [3:0]  op1;
  logic [2:0]  a1, b1;
  logic        ex1, wb1, h1;

  // lane with ROM_LAT=3
  logic [7:0]  pc3, ra3, od3, ram3;
  logic [7:0]  ad3 [3];
  logic [14:0] rd3;
  logic [3:0]  op3;
  logic [2:0]  a3, b3;
  logic        ex3, wb3, h3;

  fetch_decode #(.ROM_LAT(1), .PC_W(8)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .P_COUNT(pc1),
    .ROM_ADDR(ra1), .ROM_DATA(rd1),
    .OP_CODE(op1), .REG_A_SEL(a1), .REG_B_SEL(b1),
    .OP_DATA(od1), .RAM_ADDR(ram1),
    .EX_EN(ex1), .WB_EN(wb1), .HALTED(h1)
  );

  fetch_decode #(.ROM_LAT(3), .PC_W(8)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .P_COUNT(pc3),
    .ROM_ADDR(ra3), .ROM_DATA(rd3),
    .OP_CODE(op3), .REG_A_SEL(a3), .REG_B_SEL(b3),
    .OP_DATA(od3), .RAM_ADDR(ram3),
    .EX_EN(ex3), .WB_EN(wb3), .HALTED(h3)
  );

  // ROM models: data valid ROM_LAT edges after the address
  always @(posedge CLK) begin
    ad1    <= ra1;
    ad3[0] <= ra3;
    ad3[1] <= ad3[0];
    ad3[2] <= ad3[1];
  end

  assign rd1 = rom[ad1];
  assign rd3 = rom[ad3[2]];

  // exec stand-ins: JMP loads the target, all else steps
  always @(posedge CLK or posedge RESET) begin
    if (RESET) pc1 <= 8'h00;
    else if (ex1) pc1 <= (op1 == 4'hC) ? od1 : pc1 + 8'd1;
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) pc3 <= 8'h00;
    else if (ex3) pc3 <= (op3 == 4'hC) ? od3 : pc3 + 8'd1;
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // program order from address 0, ending at the first HLT
  task automatic build_trace();
    logic [7:0]  pc;
    logic [14:0] w;
    tr_addr.delete();
    tr_insn.delete();
    halt_idx = -1;
    pc = 8'h00;
    for (int n = 0; n < 64; n++) begin
      w = rom[pc];
      tr_addr.push_back(pc);
      tr_insn.push_back(w);
      if (w[14:11] == 4'hF) begin
        halt_idx = n;
        break;
      end
      pc = (w[14:11] == 4'hC) ? w[7:0] : pc + 8'd1;
    end
  endtask

  function automatic logic [7:0] last_mem(input int k);
    logic [7:0]  r;
    logic [14:0] w;
    r = 8'h00;
    for (int j = 0; j < k; j++) begin
      w = tr_insn[j];
      if (w[14:11] == 4'hD || w[14:11] == 4'hE)
        r = w[7:0];
    end
    return r;
  endfunction

  task automatic check_lane(
    input int L,
    input logic [7:0] ra,
    input logic [3:0] op,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [7:0] od,
    input logic [7:0] ram,
    input logic ex,
    input logic wb,
    input logic hl
  );
    int per, i, p, k;
    bit halted;
    logic [14:0] ins;
    logic [7:0] ea;
    string s;
    per = L + 3;
    i = t / per;
    p = t % per;
    halted = (halt_idx >= 0) && (i > halt_idx);
    if (halted) begin
      k = halt_idx + 1;
      ea = tr_addr[halt_idx];
    end else begin
      k = (p >= L + 1) ? i + 1 : i;
      ea = tr_addr[i];
    end
    ins = (k == 0) ? 15'h7800 : tr_insn[k-1];
    s = $sformatf("L%0d t%0d", L, t);
    chk({s, " rom_addr"}, ra, ea);
    chk({s, " ex_en"}, ex, !halted && p == L + 1);
    chk({s, " wb_en"}, wb, !halted && p == L + 2);
    chk({s, " halted"}, hl, halted);
    chk({s, " op"}, op, ins[14:11]);
    chk({s, " reg_a"}, a, ins[10:8]);
    chk({s, " reg_b"}, b, ins[7:5]);
    chk({s, " op_data"}, od, ins[7:0]);
    chk({s, " ram_addr"}, ram, last_mem(k));
  endtask

  task automatic check_reset(
    input int L,
    input logic [7:0] ra,
    input logic [3:0] op,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [7:0] od,
    input logic [7:0] ram,
    input logic ex,
    input logic wb,
    input logic hl
  );
    string s;
    s = $sformatf("L%0d reset", L);
    chk({s, " rom_addr"}, ra, 8'h00);
    chk({s, " op"}, op, 4'hF);
    chk({s, " reg_a"}, a, 3'd0);
    chk({s, " reg_b"}, b, 3'd0);
    chk({s, " op_data"}, od, 8'h00);
    chk({s, " ram_addr"}, ram, 8'h00);
    chk({s, " ex_en"}, ex, 1'b0);
    chk({s, " wb_en"}, wb, 1'b0);
    chk({s, " halted"}, hl, 1'b0);
  endtask

  task automatic fill_rom(input bit hlt_ok, input bit jmp_ok);
    logic [14:0] w;
    for (int k = 0; k < 256; k++) begin
      w = 15'($urandom);
      if (!hlt_ok && w[14:11] == 4'hF) w[14:11] = 4'h1;
      if (!jmp_ok && w[14:11] == 4'hC) w[14:11] = 4'h2;
      rom[k] = w;
    end
  endtask

  // RESET is high on entry; checks reset state, then releases
  task automatic begin_ep();
    build_trace();
    repeat (3) @(negedge CLK);
    check_reset(1, ra1, op1, a1, b1, od1, ram1, ex1, wb1, h1);
    check_reset(3, ra3, op3, a3, b3, od3, ram3, ex3, wb3, h3);
    @(negedge CLK);
    RESET = 1'b0;
    t = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      t = t + 1;
      @(negedge CLK);
      check_lane(1, ra1, op1, a1, b1, od1, ram1, ex1, wb1, h1);
      check_lane(3, ra3, op3, a3, b3, od3, ram3, ex3, wb3, h3);
    end
    #1;
  endtask

  initial begin
    #1 RESET = 1'b1;

    // MOV, ADD, SUB, ST 0x40, LDL 0x12, HLT
    fill_rom(1'b0, 1'b1);
    rom[0] = 15'h0240;
    rom[1] = 15'h0A60;
    rom[2] = 15'h14A0;
    rom[3] = 15'h7340;
    rom[4] = 15'h4012;
    rom[5] = 15'h7800;
    begin_ep();
    run_cycles(100);
    RESET = 1'b1;

    // JMP 0xFF then step past 0xFF to 0x00
    fill_rom(1'b0, 1'b0);
    rom[0] = 15'h60FF;
    begin_ep();
    run_cycles(40);
    RESET = 1'b1;

    // reset while both lanes sit in EXEC (t=10)
    fill_rom(1'b0, 1'b1);
    begin_ep();
    run_cycles(10);
    RESET = 1'b1;
    #1;
    chk("kill L1 ex_en", ex1, 1'b0);
    chk("kill L1 wb_en", wb1, 1'b0);
    chk("kill L1 op", op1, 4'hF);
    chk("kill L3 ex_en", ex3, 1'b0);
    chk("kill L3 wb_en", wb3, 1'b0);
    chk("kill L3 op", op3, 4'hF);
    chk("kill L3 pc", pc3, 8'h00);
    begin_ep();
    run_cycles(30);
    RESET = 1'b1;

    // random programs, HLT and JMP allowed
    for (int e = 0; e < 6; e++) begin
      fill_rom(1'b1, 1'b1);
      begin_ep();
      run_cycles(150);
      RESET = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
